// File: rtl/demux1to4_buf_if.sv
// -----------------------------------------------------------------------------
// demux1to4_buf_if
// Bundles the source and sink signals of the buffered 1-to-4 demultiplexer.
//
// Handshake: a word moves across a port on a rising clk edge when its valid
// and its ready are both 1 in the cycle before that edge. Ready never depends
// on valid. The source side is in/sel/in_valid -> in_ready. Channel k's sink
// side is out<k>/out_valid[k] -> out_ready[k].
//
// Modports
//   master : producer and the four consumers (drives in, sel, in_valid, out_ready)
//   slave  : the demultiplexer itself (drives in_ready, out0..3, out_valid, count0..3)
//
// Signals
//   in        [WIDTH-1:0]  source data word
//   sel       [1:0]        destination channel of `in`
//   in_valid               source presents in/sel
//   in_ready               word is accepted this cycle
//   out0..3   [WIDTH-1:0]  head word of each channel FIFO
//   out_valid [3:0]        bit k: channel k non-empty
//   out_ready [3:0]        bit k: consumer k takes the head word
//   count0..3 [CW-1:0]     occupancy of each channel FIFO
// -----------------------------------------------------------------------------
interface demux1to4_buf_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] in;
  logic [1:0]       sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic [WIDTH-1:0] out3;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [CW-1:0]    count0;
  logic [CW-1:0]    count1;
  logic [CW-1:0]    count2;
  logic [CW-1:0]    count3;

  modport master (
    output in, sel, in_valid, out_ready,
    input  in_ready, out0, out1, out2, out3, out_valid,
    input  count0, count1, count2, count3
  );

  modport slave (
    input  in, sel, in_valid, out_ready,
    output in_ready, out0, out1, out2, out3, out_valid,
    output count0, count1, count2, count3
  );
endinterface

// File: rtl/demux1to4_buf.sv
// -----------------------------------------------------------------------------
// demux1to4_buf
// Buffered 1-to-4 demultiplexer. Each accepted word is steered by `sel` into
// one of four circular FIFOs of DEPTH entries. Each FIFO drains through its
// own valid/ready port. Word order is kept within a channel. Order across
// channels is not defined.
//
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears counts, pointers and storage
//   bus    demux1to4_buf_if.slave (see the interface for signal list)
//
// Parameters
//   WIDTH  data word width
//   DEPTH  entries per channel; must be a power of two and >= 2
// -----------------------------------------------------------------------------
module demux1to4_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input logic            clk,
  input logic            reset,
  demux1to4_buf_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem    [4][DEPTH];
  logic [PW-1:0]    r_wr_ptr [4];
  logic [PW-1:0]    r_rd_ptr [4];
  logic [CW-1:0]    r_count  [4];

  logic [3:0] w_not_full;
  logic [3:0] w_not_empty;
  logic [3:0] w_push;
  logic [3:0] w_pop;

  always_comb begin
    w_not_full  = '0;
    w_not_empty = '0;
    w_pop       = '0;
    w_push      = '0;
    for (int k = 0; k < 4; k++) begin
      w_not_full[k]  = (r_count[k] != CW'(DEPTH));
      w_not_empty[k] = (r_count[k] != '0);
      w_pop[k]       = w_not_empty[k] && bus.out_ready[k];
    end
    // Readiness comes only from the selected channel's registered count.
    // A pop on a full channel in the same cycle does not free the slot until
    // the next cycle.
    w_push[bus.sel] = bus.in_valid && w_not_full[bus.sel];
  end

  assign bus.in_ready  = w_not_full[bus.sel];
  assign bus.out_valid = w_not_empty;

  assign bus.out0 = r_mem[0][r_rd_ptr[0]];
  assign bus.out1 = r_mem[1][r_rd_ptr[1]];
  assign bus.out2 = r_mem[2][r_rd_ptr[2]];
  assign bus.out3 = r_mem[3][r_rd_ptr[3]];

  assign bus.count0 = r_count[0];
  assign bus.count1 = r_count[1];
  assign bus.count2 = r_count[2];
  assign bus.count3 = r_count[3];

  // DEPTH is a power of two, so the pointers wrap naturally at PW bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        r_wr_ptr[k] <= '0;
        r_rd_ptr[k] <= '0;
        r_count[k]  <= '0;
        for (int d = 0; d < DEPTH; d++) begin
          r_mem[k][d] <= '0;
        end
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_push[k]) begin
          r_mem[k][r_wr_ptr[k]] <= bus.in;
          r_wr_ptr[k]           <= r_wr_ptr[k] + 1'b1;
        end
        if (w_pop[k]) begin
          r_rd_ptr[k] <= r_rd_ptr[k] + 1'b1;
        end
        case ({w_push[k], w_pop[k]})
          2'b10:   r_count[k] <= r_count[k] + 1'b1;
          2'b01:   r_count[k] <= r_count[k] - 1'b1;
          default: r_count[k] <= r_count[k];
        endcase
      end
    end
  end
endmodule

// File: tb/tb_demux1to4_buf.sv
// -----------------------------------------------------------------------------
// tb_demux1to4_buf
// Self-checking bench for demux1to4_buf (WIDTH=32, DEPTH=2).
// Inputs are driven 1 time unit after each rising edge. Outputs are sampled
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_demux1to4_buf;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic clk;
  logic reset;

  demux1to4_buf_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  demux1to4_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [WIDTH-1:0] exp_q [4][$];
  int n_checks;
  int n_errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] get_out(input int k);
    case (k)
      0:       return bus.out0;
      1:       return bus.out1;
      2:       return bus.out2;
      default: return bus.out3;
    endcase
  endfunction

  function automatic logic [31:0] get_cnt(input int k);
    case (k)
      0:       return 32'(bus.count0);
      1:       return 32'(bus.count1);
      2:       return 32'(bus.count2);
      default: return 32'(bus.count3);
    endcase
  endfunction

  // Called at the falling edge. It checks the outputs against the model,
  // then updates the model for the coming rising edge.
  task automatic sb_cycle();
    logic       rdy;
    logic [3:0] pop;
    rdy = (exp_q[bus.sel].size() != DEPTH);
    chk("in_ready", 32'(bus.in_ready), 32'(rdy));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("out_valid%0d", k), 32'(bus.out_valid[k]), 32'(exp_q[k].size() != 0));
      chk($sformatf("count%0d", k), get_cnt(k), 32'(exp_q[k].size()));
      if (exp_q[k].size() != 0)
        chk($sformatf("head%0d", k), get_out(k), exp_q[k][0]);
      pop[k] = (exp_q[k].size() != 0) && bus.out_ready[k];
    end
    if (bus.in_valid && rdy) exp_q[bus.sel].push_back(bus.in);
    for (int k = 0; k < 4; k++)
      if (pop[k]) void'(exp_q[k].pop_front());
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [1:0] s, input logic v, input logic [31:0] d,
                       input logic [3:0] ordy);
    bus.sel       = s;
    bus.in_valid  = v;
    bus.in        = d;
    bus.out_ready = ordy;
  endtask

  task automatic finish_cycle();
    sb_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    finish_cycle();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  sel;
    logic        vld;
    logic [31:0] data;
    logic [3:0]  ordy;
    logic        exp_rdy;
    logic [3:0]  exp_ov;
    logic [7:0]  exp_cnt;   // {count3,count2,count1,count0}
    logic        chk_en;
    logic [1:0]  chk_ch;
    logic [31:0] exp_head;
  } vec_t;

  vec_t vecs [15];

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    drive(2'd0, 1'b0, 32'h0, 4'h0);

    // ---- reset state ----
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_counts", {bus.count3, bus.count2, bus.count1, bus.count0}, 32'h0);
    chk("rst_out0", bus.out0, 32'h0);
    chk("rst_out3", bus.out3, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // ---- table: one word per channel, back-pressure, full channel ----
    vecs[0]  = '{2'd0, 1'b1, 32'hA0000000, 4'hF,    1'b1, 4'b0000, 8'h00, 1'b0, 2'd0, 32'h0};
    vecs[1]  = '{2'd1, 1'b1, 32'hA0000001, 4'hF,    1'b1, 4'b0001, 8'h01, 1'b1, 2'd0, 32'hA0000000};
    vecs[2]  = '{2'd2, 1'b1, 32'hA0000002, 4'hF,    1'b1, 4'b0010, 8'h04, 1'b1, 2'd1, 32'hA0000001};
    vecs[3]  = '{2'd3, 1'b1, 32'hA0000003, 4'hF,    1'b1, 4'b0100, 8'h10, 1'b1, 2'd2, 32'hA0000002};
    vecs[4]  = '{2'd0, 1'b0, 32'h0,        4'hF,    1'b1, 4'b1000, 8'h40, 1'b1, 2'd3, 32'hA0000003};
    vecs[5]  = '{2'd0, 1'b0, 32'h0,        4'hF,    1'b1, 4'b0000, 8'h00, 1'b0, 2'd0, 32'h0};
    vecs[6]  = '{2'd2, 1'b1, 32'h11,       4'b1011, 1'b1, 4'b0000, 8'h00, 1'b0, 2'd0, 32'h0};
    vecs[7]  = '{2'd2, 1'b1, 32'h22,       4'b1011, 1'b1, 4'b0100, 8'h10, 1'b1, 2'd2, 32'h11};
    vecs[8]  = '{2'd2, 1'b1, 32'h33,       4'b1011, 1'b0, 4'b0100, 8'h20, 1'b1, 2'd2, 32'h11};
    vecs[9]  = '{2'd0, 1'b1, 32'h44,       4'b1011, 1'b1, 4'b0100, 8'h20, 1'b1, 2'd2, 32'h11};
    vecs[10] = '{2'd2, 1'b0, 32'h0,        4'b1011, 1'b0, 4'b0101, 8'h21, 1'b1, 2'd0, 32'h44};
    vecs[11] = '{2'd2, 1'b1, 32'h33,       4'hF,    1'b0, 4'b0100, 8'h20, 1'b1, 2'd2, 32'h11};
    vecs[12] = '{2'd2, 1'b1, 32'h33,       4'hF,    1'b1, 4'b0100, 8'h10, 1'b1, 2'd2, 32'h22};
    vecs[13] = '{2'd0, 1'b0, 32'h0,        4'hF,    1'b1, 4'b0100, 8'h10, 1'b1, 2'd2, 32'h33};
    vecs[14] = '{2'd0, 1'b0, 32'h0,        4'hF,    1'b1, 4'b0000, 8'h00, 1'b0, 2'd0, 32'h0};

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].sel, vecs[i].vld, vecs[i].data, vecs[i].ordy);
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_rdy));
      chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_ov));
      chk($sformatf("vec%0d_counts", i),
          32'({bus.count3, bus.count2, bus.count1, bus.count0}), 32'(vecs[i].exp_cnt));
      if (vecs[i].chk_en)
        chk($sformatf("vec%0d_head", i), get_out(int'(vecs[i].chk_ch)), vecs[i].exp_head);
      finish_cycle();
    end

    // ---- channel 1: simultaneous push and pop across pointer wrap ----
    drive(2'd1, 1'b1, 32'd0, 4'b0000);
    tick();
    for (int i = 1; i <= 8; i++) begin
      drive(2'd1, 1'b1, 32'(i), 4'b0010);
      @(negedge clk);
      chk($sformatf("wrap%0d_count1", i), 32'(bus.count1), 32'd1);
      chk($sformatf("wrap%0d_out1", i), bus.out1, 32'(i - 1));
      finish_cycle();
    end
    drive(2'd0, 1'b0, 32'h0, 4'hF);
    tick();
    tick();

    // ---- asynchronous reset with channels 0 and 3 full ----
    drive(2'd0, 1'b1, 32'hC0, 4'h0); tick();
    drive(2'd0, 1'b1, 32'hC1, 4'h0); tick();
    drive(2'd3, 1'b1, 32'hD0, 4'h0); tick();
    drive(2'd3, 1'b1, 32'hD1, 4'h0); tick();
    drive(2'd0, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    sb_cycle();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("arst_counts", {bus.count3, bus.count2, bus.count1, bus.count0}, 32'h0);
    chk("arst_out0", bus.out0, 32'h0);
    chk("arst_out3", bus.out3, 32'h0);
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    drive(2'd3, 1'b1, 32'hBEEF, 4'h0);
    tick();
    drive(2'd0, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    chk("beef_out3", bus.out3, 32'hBEEF);
    chk("beef_out_valid", 32'(bus.out_valid), 32'b1000);
    finish_cycle();
    drive(2'd0, 1'b0, 32'h0, 4'hF);
    tick();

    // ---- random traffic ----
    for (int i = 0; i < 2000; i++) begin
      drive(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
            $urandom, 4'($urandom_range(0, 15)));
      tick();
    end
    drive(2'd0, 1'b0, 32'h0, 4'hF);
    for (int i = 0; i < 4; i++) tick();
    @(negedge clk);
    chk("drain_out_valid", 32'(bus.out_valid), 32'h0);
    for (int k = 0; k < 4; k++)
      chk($sformatf("drain_q%0d", k), 32'(exp_q[k].size()), 32'd0);

    // ---- report ----
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
